// File: rtl/mant_norm23_pkg.sv
// Shared constants, flag bit positions and FSM state encoding for the
// mantissa normaliser.
package mant_norm23_pkg;

  localparam int unsigned MANT_W  = 23;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned EXP_MAX = 255;

  // flags_out = {overflow, underflow, zero}
  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_UNF  = 1;
  localparam int unsigned FLAG_OVF  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mant_norm23_if.sv
// Adder-result input and normalised-result output handshake bundle.
// The master side feeds results and consumes outputs; the slave is the normaliser.
interface mant_norm23_if #(
  parameter int unsigned MANT_W = mant_norm23_pkg::MANT_W,
  parameter int unsigned EXP_W  = mant_norm23_pkg::EXP_W
);
  import mant_norm23_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] sum_in;
  logic              cout_in;
  logic              sub_in;
  logic [EXP_W-1:0]  exp_in;

  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_out;
  logic [EXP_W-1:0]  exp_out;
  logic              sign_out;
  logic [FLAG_W-1:0] flags_out;

  modport master (
    output in_valid, sum_in, cout_in, sub_in, exp_in, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, sign_out, flags_out
  );

  modport slave (
    input  in_valid, sum_in, cout_in, sub_in, exp_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, sign_out, flags_out
  );

endinterface

// File: rtl/mant_norm23.sv
// Post-add mantissa normaliser: takes a raw adder/subtractor result, forms its
// magnitude and shifts one bit per cycle until the leading one sits at MANT_W-1.
module mant_norm23 #(
  parameter int unsigned MANT_W = mant_norm23_pkg::MANT_W,
  parameter int unsigned EXP_W  = mant_norm23_pkg::EXP_W
) (
  input  logic          clk,
  input  logic          rst,
  mant_norm23_if.slave  bus
);
  import mant_norm23_pkg::*;

  localparam int unsigned WORK_W = MANT_W + 1;

  state_e              r_state;
  logic [WORK_W-1:0]   r_work;
  logic [EXP_W-1:0]    r_exp;
  logic                r_sign;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [MANT_W-1:0]   r_mant_out;
  logic [EXP_W-1:0]    r_exp_out;
  logic                r_sign_out;
  logic [FLAG_W-1:0]   r_flags_out;

  logic [WORK_W-1:0]   w_load_work;
  logic                w_load_sign;
  logic                w_done;
  logic [MANT_W-1:0]   w_mant;
  logic [EXP_W-1:0]    w_exp;
  logic                w_sign;
  logic [FLAG_W-1:0]   w_flags;

  // Magnitude of the incoming result; a borrow (sub without carry) means negative.
  always_comb begin
    w_load_work = {bus.cout_in, bus.sum_in};
    w_load_sign = 1'b0;
    if (bus.sub_in) begin
      if (bus.cout_in) begin
        w_load_work = {1'b0, bus.sum_in};
      end else begin
        w_load_work = {1'b0, MANT_W'(~bus.sum_in + MANT_W'(1))};
        w_load_sign = 1'b1;
      end
    end
  end

  // One normalisation rule per cycle, highest priority first.
  always_comb begin
    w_done  = 1'b1;
    w_mant  = r_work[MANT_W-1:0];
    w_exp   = r_exp;
    w_sign  = r_sign;
    w_flags = '0;
    if (r_work == '0) begin
      w_mant            = '0;
      w_exp             = '0;
      w_sign            = 1'b0;
      w_flags[FLAG_ZERO] = 1'b1;
    end else if (r_work[WORK_W-1]) begin
      if (r_exp >= EXP_W'(EXP_MAX - 1)) begin
        w_mant            = '0;
        w_exp             = EXP_W'(EXP_MAX);
        w_flags[FLAG_OVF] = 1'b1;
      end else begin
        w_mant = r_work[MANT_W:1];
        w_exp  = r_exp + EXP_W'(1);
      end
    end else if (r_work[WORK_W-2]) begin
      w_done = 1'b1;
    end else if (r_exp <= EXP_W'(1)) begin
      w_flags[FLAG_UNF] = 1'b1;
    end else begin
      w_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mant_out  <= '0;
      r_exp_out   <= '0;
      r_sign_out  <= 1'b0;
      r_flags_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_work     <= w_load_work;
            r_exp      <= bus.exp_in;
            r_sign     <= w_load_sign;
            r_in_ready <= 1'b0;
            r_state    <= S_NORM;
          end
        end
        S_NORM: begin
          if (w_done) begin
            r_mant_out  <= w_mant;
            r_exp_out   <= w_exp;
            r_sign_out  <= w_sign;
            r_flags_out <= w_flags;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_work <= {r_work[WORK_W-2:0], 1'b0};
            r_exp  <= r_exp - EXP_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.mant_out  = r_mant_out;
  assign bus.exp_out   = r_exp_out;
  assign bus.sign_out  = r_sign_out;
  assign bus.flags_out = r_flags_out;

endmodule

// File: tb/tb_mant_norm23.sv
// Directed-vector bench for mant_norm23: hand-computed results, latency,
// DONE hold behaviour and reset abort from NORM.
module tb_mant_norm23;

  localparam int unsigned MW = 23;
  localparam int unsigned EW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  mant_norm23_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

  mant_norm23 #(.MANT_W(MW), .EXP_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one result, wait for out_valid (bounded), check, optionally hold, release.
  task automatic run_vec(input string tag, input logic sub, input logic cout,
                         input logic [31:0] sum, input logic [31:0] e_in,
                         input int lat, input logic [31:0] mant, input logic [31:0] e_out,
                         input logic [31:0] sign, input logic [31:0] flags, input int hold);
    int cyc;
    bus.sub_in   = sub;
    bus.cout_in  = cout;
    bus.sum_in   = MW'(sum);
    bus.exp_in   = EW'(e_in);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.sum_in   = 23'h5A5A5A;
    bus.exp_in   = 8'hEE;
    bus.sub_in   = ~sub;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "/latency"}, 32'(cyc), 32'(lat));
    chk({tag, "/mant"}, 32'(bus.mant_out), mant);
    chk({tag, "/exp"}, 32'(bus.exp_out), e_out);
    chk({tag, "/sign"}, 32'(bus.sign_out), sign);
    chk({tag, "/flags"}, 32'(bus.flags_out), flags);
    chk({tag, "/in_ready_done"}, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      tick();
      chk({tag, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "/hold_mant"}, 32'(bus.mant_out), mant);
      chk({tag, "/hold_exp"}, 32'(bus.exp_out), e_out);
      chk({tag, "/hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "/release"}, 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  initial begin
    int seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum_in    = '0;
    bus.cout_in   = 1'b0;
    bus.sub_in    = 1'b0;
    bus.exp_in    = '0;
    tick();
    tick();
    chk("reset/out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset/outputs", 32'({bus.mant_out, bus.sign_out}), 32'd0);
    chk("reset/exp_flags", 32'({bus.exp_out, bus.flags_out}), 32'd0);
    rst = 1'b0;
    tick();
    chk("reset/in_ready", 32'(bus.in_ready), 32'd1);

    //       tag            sub   cout  sum           exp  lat mant          exp  sgn flags  hold
    run_vec("add_norm",     1'b0, 1'b0, 32'h400000,   100, 2,  32'h400000,   100, 0,  3'b000, 5);
    run_vec("add_carry",    1'b0, 1'b1, 32'h000001,   100, 2,  32'h400000,   101, 0,  3'b000, 0);
    run_vec("add_carry_ff", 1'b0, 1'b1, 32'h7FFFFF,   10,  2,  32'h7FFFFF,   11,  0,  3'b000, 0);
    run_vec("sub_pos_1",    1'b1, 1'b1, 32'h000001,   100, 24, 32'h400000,   78,  0,  3'b000, 0);
    run_vec("sub_neg_1",    1'b1, 1'b0, 32'h7FFFFF,   50,  24, 32'h400000,   28,  1,  3'b000, 0);
    run_vec("sub_neg_100",  1'b1, 1'b0, 32'h7FFF00,   120, 16, 32'h400000,   106, 1,  3'b000, 0);
    run_vec("add_shift21",  1'b0, 1'b0, 32'h000003,   30,  23, 32'h600000,   9,   0,  3'b000, 0);
    run_vec("zero",         1'b1, 1'b1, 32'h000000,   77,  2,  32'h000000,   0,   0,  3'b001, 0);
    run_vec("zero_neg",     1'b1, 1'b0, 32'h000000,   77,  2,  32'h000000,   0,   0,  3'b001, 0);
    run_vec("overflow",     1'b0, 1'b1, 32'h123456,   254, 2,  32'h000000,   255, 0,  3'b100, 0);
    run_vec("underflow",    1'b1, 1'b1, 32'h000100,   3,   4,  32'h000400,   1,   0,  3'b010, 0);
    run_vec("underflow_e1", 1'b0, 1'b0, 32'h000010,   1,   2,  32'h000010,   1,   0,  3'b010, 0);

    // Abort a long normalisation with reset part-way through NORM.
    bus.sub_in   = 1'b1;
    bus.cout_in  = 1'b1;
    bus.sum_in   = 23'h000001;
    bus.exp_in   = 8'd100;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("abort/mid_norm", 32'({bus.in_ready, bus.out_valid}), 32'b00);
    rst = 1'b1;
    tick();
    chk("abort/idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    chk("abort/outputs", 32'({bus.mant_out, bus.sign_out}), 32'd0);
    chk("abort/exp_flags", 32'({bus.exp_out, bus.flags_out}), 32'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1;
    end
    chk("abort/no_out_valid", 32'(seen), 32'd0);
    run_vec("after_abort",  1'b0, 1'b0, 32'h400000,   64,  2,  32'h400000,   64,  0,  3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mant_norm23.md
MANT_NORM23 -- requirements
Module: mant_norm23

Interface
REQ-001 Parameter MANT_W, default 23, mantissa field width.
REQ-002 Parameter EXP_W, default 8, exponent width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  upstream adder/subtractor result is valid.
REQ-006 in_ready  output  1  block can accept a result.
REQ-007 sum_in  input  MANT_W  raw adder sum.
REQ-008 cout_in  input  1  adder carry-out.
REQ-009 sub_in  input  1  1 = the sum came from a subtraction.
REQ-010 exp_in  input  EXP_W  pre-normalisation exponent.
REQ-011 out_valid  output  1  normalised result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 mant_out  output  MANT_W  normalised magnitude; leading one at bit MANT_W-1.
REQ-014 exp_out  output  EXP_W  adjusted exponent.
REQ-015 sign_out  output  1  1 = negative subtraction result.
REQ-016 flags_out  output  3  {overflow, underflow, zero}.

Function
REQ-017 FSM states SHALL be IDLE, NORM and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-018 IDLE: when in_valid=1, the block SHALL load a 24-bit work register W and the exponent E, then go to NORM.
REQ-019 Load, sub_in=0: W={cout_in,sum_in}, sign=0.
REQ-020 Load, sub_in=1 and cout_in=1: W={0,sum_in}, sign=0.
REQ-021 Load, sub_in=1 and cout_in=0: W={0,(~sum_in+1) mod 2^23}, sign=1.
REQ-022 NORM SHALL evaluate one rule per cycle, in this priority order:
 - W==0: zero=1, E=0, sign=0; go to DONE.
 - W[23]=1: W shifts right 1 and the LSB is truncated; E=E+1; go to DONE. If the incoming E is 254 or more: E=255, mantissa=0, overflow=1.
 - W[22]=1: go to DONE.
 - E<=1: underflow=1, W unchanged; go to DONE.
 - Otherwise: W shifts left 1 with zero fill; E=E-1; stay in NORM.
REQ-023 Latency: an already-normalised input accepted at cycle T SHALL give out_valid at T+2; each left shift adds 1 cycle; worst case is T+24.
REQ-024 DONE: outputs SHALL hold stable until out_ready=1, then the block returns to IDLE; there is no same-cycle re-accept (in_ready is low in DONE).
REQ-025 mant_out=W[22:0]; exp_out, sign_out and flags_out SHALL be registered and valid whenever out_valid=1.
REQ-026 Inputs SHALL be ignored outside IDLE.

Reset
REQ-027 rst=1 SHALL force IDLE in the next cycle, from any state including mid-NORM; the in-flight result is discarded with no out_valid pulse.
REQ-028 Reset values: out_valid=0, mant_out=0, exp_out=0, sign_out=0, flags_out=0; in_ready=1 after reset deasserts.

Structure
REQ-029 A shared package SHALL hold MANT_W, EXP_W, EXP_MAX=255, the flag bit indices and the FSM state enum.
REQ-030 The block SHALL be a single module with no sub-module; the negation and shifter are inline; roughly 150-250 RTL lines.

Verification
REQ-031 add, sum_in=0x400000, cout_in=0, exp_in=100 -> out at T+2: mant 0x400000, exp 100, flags 000.
REQ-032 add, cout_in=1, sum_in=0x000001, exp_in=100 -> mant 0x400000, exp 101; the truncated LSB is lost.
REQ-033 sub, cout_in=1, sum_in=0x000001, exp_in=100 -> 22 left shifts: mant 0x400000, exp 78, out_valid at T+24.
REQ-034 sub, cout_in=0, sum_in=0x7FFFFF, exp_in=50 -> magnitude 1: sign 1, mant 0x400000, exp 28.
REQ-035 Boundaries:
 - sub, cout_in=1, sum_in=0 -> zero=1, exp 0.
 - add, cout_in=1, exp_in=254 -> overflow=1, exp 255, mant 0.
 - sub, cout_in=1, sum_in=0x000100, exp_in=3 -> underflow=1, exp 1.
REQ-036 Handshake and reset: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; assert rst mid-NORM -> IDLE next cycle, no out_valid.
